// File: rtl/inv_key_scheduler.sv
// AES-128 inverse key scheduler: walks the key expansion back from round 10 to round 0.
// All 11 round keys are stored in a bank, and SelKey reads them out combinationally.
module inv_key_scheduler #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  input  logic [KW-1:0] KeySeed,
  input  logic [3:0]    SelKey,
  output logic [KW-1:0] Key,
  output logic          Ry
);

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [KW-1:0] bank [0:NR];
  logic [KW-1:0] step_key;
  logic          load, step;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: inverse as x^254 (so 0 maps to 0), followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t, r, s;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Recover the round r-1 key from the round r key
  function automatic logic [KW-1:0] inv_round(input logic [KW-1:0] k, input logic [CW-1:0] r);
    logic [WW-1:0] k0, k1, k2, k3, n0, n1, n2, n3, rw, sw;
    {k0, k1, k2, k3} = k;
    n3 = k3 ^ k2;
    n2 = k2 ^ k1;
    n1 = k1 ^ k0;
    rw = {n3[23:0], n3[31:24]};
    sw = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    n0 = k0 ^ sw ^ {rcon(r), 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (En) state_next = S_RUN;
      S_RUN:          if (cnt == CW'(1)) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    Ry   = 1'b0;
    case (state)
      S_IDLE:  load = En;
      S_RUN:   step = 1'b1;
      S_DONE: begin
        load = En;
        Ry   = 1'b1;
      end
      default: ;
    endcase
  end

  assign step_key = inv_round(bank[cnt], cnt);

  // Bank and round counter; the counter only steps while RUN, so it stops at 0
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
      for (int i = 0; i <= int'(NR); i++) bank[i] <= '0;
    end else if (load) begin
      bank[NR] <= KeySeed;
      cnt      <= CW'(NR);
    end else if (step && cnt != '0) begin
      bank[cnt - CW'(1)] <= step_key;
      cnt                <= cnt - CW'(1);
    end
  end

  assign Key = (SelKey <= CW'(NR)) ? bank[SelKey] : '0;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Directed bench for inv_key_scheduler using the FIPS-197 A.1 and C.1 key schedules.
module tb_inv_key_scheduler;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic [127:0] KeySeed;
  logic [3:0]   SelKey;
  logic [127:0] Key;
  logic         Ry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [13];

  localparam logic [127:0] SEED_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEED_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  inv_key_scheduler dut (
    .Clk(Clk), .Rst(Rst), .En(En), .KeySeed(KeySeed),
    .SelKey(SelKey), .Key(Key), .Ry(Ry)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic read_key(input logic [3:0] sel, input logic [127:0] exp, input string name);
    SelKey = sel;
    #1;
    check(name, Key, exp);
  endtask

  // Accept En on the next edge, then count edges until Ry rises (bounded)
  task automatic start_and_wait(input logic [127:0] seed, output int n);
    @(negedge Clk);
    KeySeed = seed;
    En = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    En = 1'b0;
    check("ry_low_after_accept", 128'(Ry), 128'(0));
    n = 0;
    while (!Ry && n < 20) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic sweep_a1(input string tag);
    for (int i = 0; i < 13; i++)
      read_key(vecs[i].sel, vecs[i].exp, $sformatf("%s_sel%0d", tag, vecs[i].sel));
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[11] = '{4'd11, 128'h0};
    vecs[12] = '{4'd15, 128'h0};

    Rst = 1'b0; En = 1'b0; KeySeed = '0; SelKey = '0;
    #23;
    check("reset_ry", 128'(Ry), 128'(0));
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_ry", 128'(Ry), 128'(0));
    for (int s = 0; s < 16; s++) read_key(4'(s), 128'h0, $sformatf("reset_key%0d", s));

    // FIPS-197 A.1 run and full sweep
    start_and_wait(SEED_A1, n);
    check("a1_latency", 128'(n), 128'(10));
    sweep_a1("a1");

    // En pulses (with a different seed) at RUN cycles 3 and 7 must be ignored
    @(negedge Clk);
    KeySeed = SEED_A1; En = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    En = 1'b0;
    n = 0;
    while (!Ry && n < 20) begin
      if (n == 2 || n == 6) begin KeySeed = SEED_C1; En = 1'b1; end
      else begin KeySeed = '0; En = 1'b0; end
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
    En = 1'b0;
    check("ignore_en_latency", 128'(n), 128'(10));
    sweep_a1("ign");

    // Reset mid-RUN: abort at RUN cycle 5
    @(negedge Clk);
    KeySeed = SEED_A1; En = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    En = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("abort_ry", 128'(Ry), 128'(0));
    read_key(4'd10, 128'h0, "abort_key10");
    read_key(4'd9, 128'h0, "abort_key9");
    @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    check("abort_idle_ry", 128'(Ry), 128'(0));
    start_and_wait(SEED_A1, n);
    check("post_abort_latency", 128'(n), 128'(10));
    read_key(4'd0, vecs[10].exp, "post_abort_key0");
    read_key(4'd1, vecs[9].exp, "post_abort_key1");

    // Back-to-back from DONE with the C.1 seed
    start_and_wait(SEED_C1, n);
    check("c1_latency", 128'(n), 128'(10));
    read_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f, "c1_key0");
    read_key(4'd10, SEED_C1, "c1_key10");
    read_key(4'd12, 128'h0, "c1_key12");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
